// File: rtl/ahblite_btn_in_pkg.sv
// Shared definitions for the AHB-Lite push-button input peripheral:
// HTRANS encodings, register word offsets and the ID constant.
package ahb_btn_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Word index, i.e. HADDR[3:2]
  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_EDGE  = 2'd1,
    REG_IRQEN = 2'd2,
    REG_ID    = 2'd3
  } reg_off_e;

  localparam logic [31:0] ID_BASE = 32'hB770_0000;

  // ID register value: fixed base with the button count in the low bits
  function automatic logic [31:0] btn_id(input int unsigned n);
    return ID_BASE | 32'(n);
  endfunction

endpackage

// File: rtl/ahblite_btn_in_if.sv
// AHB-Lite slave-side signal bundle for the push-button peripheral.
// master drives the address/control/write data, slave returns read data and status.
interface ahblite_btn_in_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahblite_btn_in_debounce.sv
// One button bit: two-flop synchroniser followed by a debounce counter.
// The counter runs only while the synchronised level disagrees with the
// accepted level; any return to agreement clears it. After DB_CYCLES
// consecutive disagreeing cycles the new level is accepted.
module btn_debounce #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Next-state: synchroniser shift, debounce count and acceptance
  always_comb begin
    sync1_d  = btn_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  // High in the cycle whose closing edge takes stable from 0 to 1
  assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/ahblite_btn_in.sv
// AHB-Lite slave exposing debounced push-buttons to the CPU.
// Registers: DATA (RO), EDGE (W1C rising-edge latch), IRQEN (RW), ID (RO).
// Zero wait states; read data is registered at the end of the address phase.
// Optional feature macro: BTN_IRQ_EN builds the IRQEN register and IRQ output;
// without it IRQEN reads 0 and IRQ is tied low.
module ahblite_btn_in
  import ahb_btn_pkg::*;
#(
  parameter int NUM_BTN   = 8,
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic               HCLK,
  input  logic               HRESET,
  ahblite_btn_in_if.slave    bus,
  input  logic [NUM_BTN-1:0] btn,
  output logic               IRQ
);

  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] rise;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
    ) u_db (
      .clk      (HCLK),
      .rst      (HRESET),
      .btn_i    (btn[i]),
      .stable_o (stable[i]),
      .rise_o   (rise[i])
    );
  end

  logic               dp_valid_q, dp_valid_d;
  logic               dp_write_q, dp_write_d;
  logic [1:0]         dp_addr_q, dp_addr_d;
  logic [31:0]        hrdata_q, hrdata_d;
  logic [NUM_BTN-1:0] edge_q, edge_d;
  logic [NUM_BTN-1:0] irqen_d;
  logic [NUM_BTN-1:0] edge_clr;
  logic               accept;
  logic               wr_en;
  logic [31:0]        stable_w, edge_w, irqen_w;

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign wr_en  = dp_valid_q & dp_write_q;

  // Address phase capture; held while the bus is stalled elsewhere
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    if (bus.HREADY) begin
      dp_valid_d = accept;
      dp_write_d = bus.HWRITE;
      dp_addr_d  = bus.HADDR[3:2];
    end
  end

  // EDGE: W1C from the data phase, a same-cycle rising edge wins over the clear
  always_comb begin
    edge_clr = '0;
    if (wr_en && dp_addr_q == REG_EDGE) begin
      edge_clr = bus.HWDATA[NUM_BTN-1:0];
    end
    edge_d = (edge_q & ~edge_clr) | rise;
  end

`ifdef BTN_IRQ_EN
  logic [NUM_BTN-1:0] irqen_q;
  logic               irq_q, irq_d;

  // IRQEN write and registered interrupt level
  always_comb begin
    irqen_d = irqen_q;
    if (wr_en && dp_addr_q == REG_IRQEN) begin
      irqen_d = bus.HWDATA[NUM_BTN-1:0];
    end
    irq_d = |(edge_q & irqen_q);
  end

  // IRQ state registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      irqen_q <= irqen_d;
      irq_q   <= irq_d;
    end
  end

  assign IRQ = irq_q;
`else
  assign irqen_d = '0;
  assign IRQ     = 1'b0;
`endif

  // Zero-extend the NUM_BTN-wide registers to the bus width; reads see post-write values
  always_comb begin
    stable_w               = '0;
    edge_w                 = '0;
    irqen_w                = '0;
    stable_w[NUM_BTN-1:0]  = stable;
    edge_w[NUM_BTN-1:0]    = edge_d;
    irqen_w[NUM_BTN-1:0]   = irqen_d;
  end

  // Read mux, loaded at the end of an accepted read address phase
  always_comb begin
    hrdata_d = hrdata_q;
    if (accept && !bus.HWRITE) begin
      case (reg_off_e'(bus.HADDR[3:2]))
        REG_DATA:  hrdata_d = stable_w;
        REG_EDGE:  hrdata_d = edge_w;
        REG_IRQEN: hrdata_d = irqen_w;
        default:   hrdata_d = btn_id(NUM_BTN);
      endcase
    end
  end

  // Bus pipeline and register-file state
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      hrdata_q   <= '0;
      edge_q     <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      hrdata_q   <= hrdata_d;
      edge_q     <= edge_d;
    end
  end

  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  // Bus bits with no function in this slave (size, byte lanes, upper address)
  logic unused_bus;
  assign unused_bus = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], bus.HSIZE, bus.HWDATA};

endmodule

// File: tb/tb_ahblite_btn_in.sv
// Bench for ahblite_btn_in with DB_CYCLES=4. Reads are queued with their
// expected value when the address phase is driven and compared in the data phase.
module tb_ahblite_btn_in;
  import ahb_btn_pkg::*;

  localparam int NB = 8;
  localparam logic [31:0] ID_EXP = 32'hB770_0008;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn;
  logic          irq;

  ahblite_btn_in_if bus ();

  ahblite_btn_in #(
    .NUM_BTN   (NB),
    .DB_CYCLES (4),
    .DB_W      (16)
  ) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.slave),
    .btn    (btn),
    .IRQ    (irq)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [31:0] exp;
    logic [63:0] nm;
  } sb_t;

  typedef struct packed {
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [3:0]  off;
    logic [31:0] wd;
    logic [31:0] exp;
    logic [63:0] nm;
  } vec_t;

  sb_t         sbq[$];
  vec_t        tbl[$];
  logic [31:0] wdata_next;

  task automatic check(input logic [63:0] nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %0s: got %h expected %h", nm, act, exp);
  endtask

  // One bus cycle: drive an address phase (and the previous write's data), step one edge
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr, input logic [3:0] off,
                     input logic [31:0] wd, input logic [31:0] exp, input logic [63:0] nm);
    logic rd;
    sb_t  e;
    rd          = sel && tr[1] && !wr;
    bus.HSEL    = sel;
    bus.HTRANS  = tr;
    bus.HWRITE  = wr;
    bus.HADDR   = {28'h0, off};
    bus.HWDATA  = wdata_next;
    wdata_next  = wd;
    if (rd) sbq.push_back('{exp, nm});
    @(posedge clk);
    #1;
    check("hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
    check("hresp", {31'b0, bus.HRESP}, 32'd0);
    if (rd) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard: got empty queue expected entry for %0s", nm);
      end else begin
        e = sbq.pop_front();
        check(e.nm, bus.HRDATA, e.exp);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, T_IDLE, 1'b0, 4'h0, 32'h0, 32'h0, "idle");
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp, input logic [63:0] nm);
    cyc(1'b1, T_NSEQ, 1'b0, off, 32'h0, exp, nm);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] data);
    cyc(1'b1, T_NSEQ, 1'b1, off, data, 32'h0, "wr");
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) cyc(tbl[i].sel, tbl[i].tr, tbl[i].wr, tbl[i].off, tbl[i].wd, tbl[i].exp, tbl[i].nm);
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.HSEL   = 1'b0;
    bus.HTRANS = T_IDLE;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HSIZE  = 3'b010;
    bus.HREADY = 1'b1;
    bus.HWDATA = 32'h0;
    wdata_next = 32'h0;
    btn        = '0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hrdata", bus.HRDATA, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;

    // Reset values of every register
    tbl.push_back('{1'b1, T_NSEQ, 1'b0, 4'h0, 32'h0, 32'h0, "rst_data"});
    tbl.push_back('{1'b1, T_NSEQ, 1'b0, 4'h4, 32'h0, 32'h0, "rst_edge"});
    tbl.push_back('{1'b1, T_NSEQ, 1'b0, 4'h8, 32'h0, 32'h0, "rst_irqen"});
    tbl.push_back('{1'b1, T_NSEQ, 1'b0, 4'hC, 32'h0, ID_EXP, "rst_id"});
    run_tbl();

    // Press btn[0]: accepted DB_CYCLES+2 edges later
    btn[0] = 1'b1;
    for (int k = 0; k < 4; k++) rd(4'h0, 32'h0, "data_pre");
    idle(3);
    rd(4'h0, 32'h1, "data_prs");
    rd(4'h4, 32'h1, "edge_prs");

    // W1C clears, read right behind the write sees the cleared value
    wr(4'h4, 32'h1);
    rd(4'h4, 32'h0, "edge_w1c");
    rd(4'h0, 32'h1, "data_hld");
    btn[0] = 1'b0;
    idle(10);
    rd(4'h0, 32'h0, "data_rel");

    // btn[1] becomes stable on the very edge that commits a W1C of bit 1
    btn[1] = 1'b1;
    idle(4);
    wr(4'h4, 32'h2);
    rd(4'h4, 32'h2, "edge_win");
    rd(4'h4, 32'h2, "edge_wn2");
    btn[1] = 1'b0;
    idle(10);
    wr(4'h4, 32'hFF);
    rd(4'h4, 32'h0, "edge_clr");

    // 3-cycle glitch on btn[3] is rejected
    btn[3] = 1'b1;
    idle(3);
    btn[3] = 1'b0;
    idle(10);
    rd(4'h0, 32'h0, "glt_data");
    rd(4'h4, 32'h0, "glt_edge");

`ifdef BTN_IRQ_EN
    wr(4'h8, 32'h1);
    rd(4'h8, 32'h1, "irqen_rd");
    btn[0] = 1'b1;
    idle(8);
    check("irq_set", {31'b0, irq}, 32'h1);
    wr(4'h4, 32'h1);
    idle(1);
    check("irq_hold", {31'b0, irq}, 32'h1);
    idle(1);
    check("irq_clr", {31'b0, irq}, 32'h0);
`else
    wr(4'h8, 32'hFF);
    rd(4'h8, 32'h0, "irqen_rd");
    btn[0] = 1'b1;
    idle(8);
    check("irq_off", {31'b0, irq}, 32'h0);
    wr(4'h4, 32'h1);
    idle(1);
`endif
    btn[0] = 1'b0;
    idle(10);

    // Back-to-back traffic with ignored HSEL=0 / IDLE / BUSY writes
    btn[2] = 1'b1;
    idle(8);
    tbl.push_back('{1'b0, T_NSEQ, 1'b1, 4'h4, 32'h4, 32'h0, "wr_nosel"});
    tbl.push_back('{1'b1, T_NSEQ, 1'b0, 4'h4, 32'h0, 32'h4, "bb_edge1"});
    tbl.push_back('{1'b1, T_IDLE, 1'b1, 4'h4, 32'h4, 32'h0, "wr_idle"});
    tbl.push_back('{1'b1, T_BUSY, 1'b1, 4'h4, 32'h4, 32'h0, "wr_busy"});
    tbl.push_back('{1'b1, T_NSEQ, 1'b0, 4'h4, 32'h0, 32'h4, "bb_edge2"});
    tbl.push_back('{1'b1, T_NSEQ, 1'b1, 4'h4, 32'h4, 32'h0, "bb_w1c"});
    tbl.push_back('{1'b1, T_NSEQ, 1'b0, 4'h4, 32'h0, 32'h0, "bb_raw"});
    tbl.push_back('{1'b0, T_IDLE, 1'b0, 4'h0, 32'h0, 32'h0, "bb_idle"});
    tbl.push_back('{1'b1, T_NSEQ, 1'b0, 4'h0, 32'h0, 32'h4, "bb_data"});
    tbl.push_back('{1'b1, T_SEQ,  1'b0, 4'hC, 32'h0, ID_EXP, "bb_id"});
    run_tbl();
    idle(1);
    check("rd_hold", bus.HRDATA, ID_EXP);

    // Reset lands in a write data phase: write dropped, everything back to 0
    btn[2] = 1'b0;
    idle(10);
    wr(4'h8, 32'h3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_hrdata", bus.HRDATA, 32'h0);
    check("mid_irq", {31'b0, irq}, 32'h0);
    rd(4'h0, 32'h0, "mid_data");
    rd(4'h4, 32'h0, "mid_edge");
    rd(4'h8, 32'h0, "mid_irqen");
    rd(4'hC, ID_EXP, "mid_id");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
